// File: rtl/mult_div_if.sv
// Operand/result bundle between the MIPS control FSM and the multiply/divide unit.
interface mult_div_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV: 32 shift-add or restoring-divide steps on operand
// magnitudes, followed by a sign-fix cycle that writes HI/LO.
module mult_div_unit (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        accept;
  logic        dz_req;

  logic        busy_q;
  logic        done_q;
  logic        div_zero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        op_p0;
  logic        neg_lo_p0;
  logic        neg_hi_p0;
  logic        dz_p0;
  logic [31:0] mag_a_p0;
  logic [31:0] mag_b_p0;

  logic [63:0] acc_p1;
  logic [63:0] acc_nxt;
  logic [63:0] prod_fix;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        keep;

  // The most negative value maps to unsigned 2^31, which is the correct magnitude.
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    logic signed [31:0] n;
    n = -v;
    return v[31] ? n : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dz_req    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          dz_req    = bus.op && (bus.b == 32'd0);
          state_nxt = dz_req ? FIX : RUN;
        end
      end
      RUN: begin
        if (cnt == 5'd31) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration step. MULT: acc = {partial product, remaining multiplier bits}.
  // DIV: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    mul_sum  = {1'b0, acc_p1[63:32]} + (acc_p1[0] ? {1'b0, mag_a_p0} : 33'd0);
    rem_sh   = {acc_p1[63:32], acc_p1[31]};
    trial    = {1'b0, rem_sh} - {2'b00, mag_b_p0};
    // Borrow shows in both top bits; a kept result always fits in 32 bits.
    keep     = (trial[33:32] == 2'b00);
    if (op_p0) begin
      acc_nxt = keep ? {trial[31:0], acc_p1[30:0], 1'b1}
                     : {rem_sh[31:0], acc_p1[30:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_p1[31:1]};
    end
    prod_fix = neg64(acc_p1, neg_lo_p0);
  end

  // Control state and architecturally visible result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state == FIX);
      if (accept) begin
        cnt        <= 5'd0;
        div_zero_q <= 1'b0;
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
      end
      if (state == FIX) begin
        if (dz_p0) begin
          div_zero_q <= 1'b1;
        end else if (op_p0) begin
          hi_q <= neg32(acc_p1[63:32], neg_hi_p0);
          lo_q <= neg32(acc_p1[31:0], neg_lo_p0);
        end else begin
          hi_q <= prod_fix[63:32];
          lo_q <= prod_fix[31:0];
        end
      end
    end
  end

  // Operand latch (p0) and iteration accumulator (p1)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= bus.op;
      mag_a_p0  <= mag32(bus.a);
      mag_b_p0  <= mag32(bus.b);
      neg_lo_p0 <= bus.a[31] ^ bus.b[31];
      neg_hi_p0 <= bus.op & bus.a[31];
      dz_p0     <= dz_req;
      acc_p1    <= bus.op ? {32'd0, mag32(bus.a)} : {32'd0, mag32(bus.b)};
    end else if (state == RUN) begin
      acc_p1 <= acc_nxt;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against a plain-arithmetic reference.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_dz = 1'b0;

  always #5 clk = ~clk;

  mult_div_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end
  endfunction

  // Called at #1 after an edge; start is sampled at the next edge.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    logic        e_dz, held, got;
    int          e_lat, k, busy_cnt;
    if (op && b == 32'd0) begin
      e_hi = m_hi; e_lo = m_lo; e_dz = 1'b1; e_lat = 1;
    end else begin
      ref_op(op, a, b, e_hi, e_lo);
      e_dz = 1'b0; e_lat = 33;
    end
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    chk({tag, "/busy_at_accept"}, 64'(bus.busy), 64'd1);
    if (!e_dz) chk({tag, "/dz_cleared"}, 64'(bus.div_zero), 64'd0);
    busy_cnt = 1; held = 1'b1; got = 1'b0; k = 0;
    while (!got && k < 40) begin
      if (k == 5) bus.start = 1'b1;
      if (k == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      k++;
      if (bus.done) got = 1'b1;
      else if (bus.busy) busy_cnt++;
      if (!got && (bus.hi !== m_hi || bus.lo !== m_lo)) held = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "/latency"}, 64'(k), 64'(e_lat));
    chk({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(e_lat));
    chk({tag, "/busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "/hilo_held"}, 64'(held), 64'd1);
    chk({tag, "/hi"}, 64'(bus.hi), 64'(e_hi));
    chk({tag, "/lo"}, 64'(bus.lo), 64'(e_lo));
    chk({tag, "/div_zero"}, 64'(bus.div_zero), 64'(e_dz));
    m_hi = e_hi; m_lo = e_lo; m_dz = e_dz;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        seen_done;
    logic        r_op;
    logic [31:0] r_a, r_b;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/busy", 64'(bus.busy), 64'd0);
    chk("reset/done", 64'(bus.done), 64'd0);
    chk("reset/div_zero", 64'(bus.div_zero), 64'd0);
    chk("reset/hi", 64'(bus.hi), 64'd0);
    chk("reset/lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_7_m3/hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mul_7_m3/lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
    chk("mul_min_min/hi_const", 64'(bus.hi), 64'h4000_0000);
    run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_m1_m1/lo_const", 64'(bus.lo), 64'd1);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2/lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_m7_2/hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_m1/lo_const", 64'(bus.lo), 64'h8000_0000);

    run_op("mul_setup", 1'b0, 32'h0001_2345, 32'hFFF0_0678);
    run_op("div_by_zero", 1'b1, 32'd100, 32'd0);
    // Accepted in the done cycle; must clear div_zero
    run_op("b2b_after_dz", 1'b0, 32'd3, 32'd5);
    run_op("b2b_div", 1'b1, 32'd1000, 32'hFFFF_FFF9);

    // Mid-run restart attempt, then reset at cycle 10
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd50; bus.b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("midrun_start/busy", 64'(bus.busy), 64'd1);
    chk("midrun_start/div_zero", 64'(bus.div_zero), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort/busy", 64'(bus.busy), 64'd0);
    chk("abort/done", 64'(bus.done), 64'd0);
    chk("abort/div_zero", 64'(bus.div_zero), 64'd0);
    chk("abort/hi", 64'(bus.hi), 64'd0);
    chk("abort/lo", 64'(bus.lo), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("abort/no_done", 64'(seen_done), 64'd0);
    run_op("div_9_4", 1'b1, 32'd9, 32'd4);
    chk("div_9_4/lo_const", 64'(bus.lo), 64'd2);
    chk("div_9_4/hi_const", 64'(bus.hi), 64'd1);

    for (int i = 0; i < 30; i++) begin
      r_op = 1'($urandom);
      r_a  = pick();
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
